// File: rtl/data_memory_if.sv
// Load/store stall handshake between the CPU (master) and data memory (slave).
interface data_memory_if #(
  parameter int ADDR_W = 8
);
  logic              READ;
  logic              WRITE;
  logic [ADDR_W-1:0] ADDRESS;
  logic [7:0]        WRITEDATA;
  logic [7:0]        READDATA;
  logic              BUSYWAIT;

  modport master (
    output READ,
    output WRITE,
    output ADDRESS,
    output WRITEDATA,
    input  READDATA,
    input  BUSYWAIT
  );

  modport slave (
    input  READ,
    input  WRITE,
    input  ADDRESS,
    input  WRITEDATA,
    output READDATA,
    output BUSYWAIT
  );
endinterface

// File: rtl/data_memory.sv
// Byte-wide data memory with a fixed multi-cycle access latency.
// Stalls the CPU via BUSYWAIT and releases it for one DONE cycle.
module data_memory #(
  parameter int DEPTH         = 256,
  parameter int ADDR_W        = 8,
  parameter int ACCESS_CYCLES = 5
) (
  input logic           CLK,
  input logic           RESET,
  data_memory_if.slave  bus
);

  localparam int CW = $clog2(ACCESS_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              wr_q, wr_d;
  logic              busy;
  logic              mem_we;

  logic [7:0] mem [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    busy    = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = bus.READ | bus.WRITE;
        if (busy) begin
          addr_d  = bus.ADDRESS;
          wdata_d = bus.WRITEDATA;
          wr_d    = bus.WRITE;
          cnt_d   = CW'(1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem[addr_q];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

  // Storage is never cleared; reset only blocks a commit in flight.
  always_ff @(posedge CLK) begin
    if (mem_we && !RESET) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign bus.BUSYWAIT = busy & ~RESET;
  assign bus.READDATA = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: reference memory model and a queue of
// expected READDATA values checked in each access's DONE cycle.
module tb_data_memory;

  localparam int ACC = 5;

  logic clk;
  logic rst;

  data_memory_if #(.ADDR_W(8)) bus ();

  data_memory #(
    .DEPTH         (256),
    .ADDR_W        (8),
    .ACCESS_CYCLES (ACC)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         n_chk;
  int         n_fail;
  logic [7:0] mdl [256];
  logic [7:0] rd_last;
  logic [7:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; returns just after the posedge ending DONE
  // with the request still held, as a slow CPU would.
  task automatic access(input logic wr, input logic rd,
                        input logic [7:0] a, input logic [7:0] d,
                        input int chg_at, input logic [7:0] a2,
                        input logic [7:0] d2, input int drop_at);
    int busy_n;
    bus.WRITE     = wr;
    bus.READ      = rd;
    bus.ADDRESS   = a;
    bus.WRITEDATA = d;
    if (wr) begin
      mdl[a] = d;
    end else begin
      rd_last = mdl[a];
    end
    sb_q.push_back(rd_last);
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.BUSYWAIT) break;
      busy_n++;
      if (i == chg_at) begin
        bus.ADDRESS   = a2;
        bus.WRITEDATA = d2;
      end
      if (i == drop_at) begin
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
      end
    end
    check("busy_len", busy_n, ACC);
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      check("rdata_done", bus.READDATA, sb_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.BUSYWAIT, 0);
    check("idle_rdata", bus.READDATA, rd_last);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    access(1'b1, 1'b0, a, d, -1, 8'h00, 8'h00, -1);
  endtask

  task automatic rd(input logic [7:0] a);
    access(1'b0, 1'b1, a, 8'h00, -1, 8'h00, 8'h00, -1);
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    rd_last       = 8'h00;
    rst           = 1'b1;
    bus.READ      = 1'b1;
    bus.WRITE     = 1'b0;
    bus.ADDRESS   = 8'h00;
    bus.WRITEDATA = 8'h00;

    repeat (2) begin
      @(negedge clk);
      check("rst_busy", bus.BUSYWAIT, 0);
      check("rst_rdata", bus.READDATA, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycle();

    wr(8'h3C, 8'hA5);
    idle_cycle();
    rd(8'h3C);
    idle_cycle();

    wr(8'h01, 8'h11);
    wr(8'h02, 8'h22);
    rd(8'h01);
    rd(8'h02);
    idle_cycle();

    wr(8'h20, 8'h99);
    access(1'b1, 1'b0, 8'h10, 8'h55, 2, 8'h20, 8'hFF, -1);
    idle_cycle();
    rd(8'h10);
    rd(8'h20);
    idle_cycle();

    access(1'b1, 1'b1, 8'h40, 8'h77, -1, 8'h00, 8'h00, -1);
    idle_cycle();
    rd(8'h40);
    idle_cycle();

    access(1'b1, 1'b0, 8'h60, 8'h3C, -1, 8'h00, 8'h00, 1);
    idle_cycle();
    rd(8'h60);
    idle_cycle();

    wr(8'h50, 8'h0F);
    idle_cycle();
    bus.WRITE     = 1'b1;
    bus.ADDRESS   = 8'h50;
    bus.WRITEDATA = 8'hF0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_busy", bus.BUSYWAIT, 1);
      @(posedge clk);
      #1;
    end
    rst       = 1'b1;
    bus.WRITE = 1'b0;
    @(negedge clk);
    check("abort_rst_busy", bus.BUSYWAIT, 0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    rd_last = 8'h00;
    @(negedge clk);
    check("abort_idle_busy", bus.BUSYWAIT, 0);
    check("abort_rdata", bus.READDATA, 0);
    @(posedge clk);
    #1;
    rd(8'h50);
    idle_cycle();

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
